// File: rtl/alu_defs.sv
// Shared op encodings and MDU state type for the EX-stage ALU/MDU.
package alu_defs;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_ABS  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_t;

endpackage

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit: start/busy handshake, latched operands,
// architectural HI/LO registers written when the cycle counter expires.
module mdu_core
  import alu_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, sdiv_d, udiv_d;
  logic [WIDTH-1:0]   squo_mag, srem_mag, quo_s, rem_s, quo_u, rem_u;

  // Sign-extending both operands to 2*WIDTH makes the truncated product exact for signed.
  assign prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
  assign prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};

  // Signed divide on magnitudes, then restore signs (truncation toward zero).
  assign a_neg    = a_reg[WIDTH-1];
  assign b_neg    = b_reg[WIDTH-1];
  assign a_mag    = a_neg ? ({WIDTH{1'b0}} - a_reg) : a_reg;
  assign b_mag    = b_neg ? ({WIDTH{1'b0}} - b_reg) : b_reg;
  assign div_zero = (b_reg == '0);
  assign sdiv_d   = div_zero ? WIDTH'(1) : b_mag;
  assign udiv_d   = div_zero ? WIDTH'(1) : b_reg;
  assign squo_mag = a_mag / sdiv_d;
  assign srem_mag = a_mag % sdiv_d;
  assign quo_s    = (a_neg ^ b_neg) ? ({WIDTH{1'b0}} - squo_mag) : squo_mag;
  assign rem_s    = a_neg ? ({WIDTH{1'b0}} - srem_mag) : srem_mag;
  assign quo_u    = a_reg / udiv_d;
  assign rem_u    = a_reg % udiv_d;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_next = RUN;
              a_next     = src_a;
              b_next     = src_b;
              op_next    = md_op;
              count_next = (md_op == MD_MULT || md_op == MD_MULTU) ?
                           CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
            end
            MD_MTHI: hi_next = src_a;
            MD_MTLO: lo_next = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          state_next = IDLE;
          case (op_reg)
            MD_MULT:  {hi_next, lo_next} = prod_s;
            MD_MULTU: {hi_next, lo_next} = prod_u;
            MD_DIV:   if (!div_zero) begin hi_next = rem_s; lo_next = quo_s; end
            MD_DIVU:  if (!div_zero) begin hi_next = rem_u; lo_next = quo_u; end
            default: ;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= MD_NOP;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execution unit: combinational ALU with overflow flagging plus
// the multi-cycle MDU holding HI/LO.
module alu_mdu
  import alu_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SW-1:0] shamt;
  logic [WIDTH:0] sum_ext, diff_ext;

  assign shamt    = src_b[SW-1:0];
  assign sum_ext  = {src_a[WIDTH-1], src_a} + {src_b[WIDTH-1], src_b};
  assign diff_ext = {src_a[WIDTH-1], src_a} - {src_b[WIDTH-1], src_b};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        overflow = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
      end
      ALU_SUB: begin
        result   = diff_ext[WIDTH-1:0];
        overflow = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
      end
      // |most-negative| is unrepresentable: report overflow and return zero.
      ALU_ABS: begin
        if (src_a == MOST_NEG) overflow = 1'b1;
        else result = src_a[WIDTH-1] ? ({WIDTH{1'b0}} - src_a) : src_a;
      end
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      ALU_XOR:  result = src_a ^ src_b;
      ALU_NOR:  result = ~(src_a | src_b);
      ALU_SLL:  result = src_a << shamt;
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = $signed(src_a) >>> shamt;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk   (clk),
    .reset (reset),
    .src_a (src_a),
    .src_b (src_b),
    .md_op (md_op),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

endmodule
